// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter
// Shares one OBI-style req/gnt/rvalid memory port between the instruction
// fetch requester and the load/store requester. The arbitration choice is
// frozen while a request waits on the memory side, so the address and
// payload stay stable until accepted. Every accepted request records its
// source in an in-order tracking FIFO, and each response is routed back to
// the requester that issued it with no added latency.

module rv32i_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,  // 1..8
    parameter int unsigned STARVE_LIMIT    = 4   // 1..15
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    // instruction fetch requester
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    // load/store requester
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    // shared memory port
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    // status
    output logic        busy_o,
    output logic        protocol_err_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STV_W = 4;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_ZERO = {STV_W{1'b0}};
    localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

    // FIFO entry encoding: 1 = instruction fetch, 0 = load/store
    localparam logic SRC_INSTR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } state_e;

    // Circular pointer advance, wrapping at the FIFO depth (depth need not
    // be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                     r_state;
    state_e                     w_state_nxt;
    logic [STV_W-1:0]           r_starve;
    logic [STV_W-1:0]           w_starve_nxt;
    logic [MAX_OUTSTANDING-1:0] r_src;
    logic [PTR_W-1:0]           r_wptr;
    logic [PTR_W-1:0]           r_rptr;
    logic [CNT_W-1:0]           r_count;
    logic                       r_protocol_err;

    logic w_sel_instr;
    logic w_sel_req;
    logic w_full;
    logic w_empty;
    logic w_issue;
    logic w_grant;
    logic w_instr_gnt;
    logic w_data_gnt;
    logic w_head_instr;
    logic w_pop;
    logic w_stray;

    assign w_full  = (r_count == CNT_MAX);
    assign w_empty = (r_count == CNT_ZERO);

    // Source selection: live in IDLE, frozen while a request is pending.
    always_comb begin
        w_sel_instr = 1'b0;
        case (r_state)
            ST_LOCK_I: w_sel_instr = 1'b1;
            ST_LOCK_D: w_sel_instr = 1'b0;
            ST_IDLE: begin
                if (instr_req_i && data_req_i) begin
                    // data has priority unless fetch has waited long enough
                    w_sel_instr = (r_starve == STV_MAX);
                end else if (instr_req_i) begin
                    w_sel_instr = 1'b1;
                end else begin
                    w_sel_instr = 1'b0;
                end
            end
            default: w_sel_instr = 1'b0;
        endcase
    end

    // A full FIFO blocks issue outright, even when a pop happens this cycle.
    // Reset gating keeps every output at its reset value while rst_ni is low.
    assign w_sel_req   = w_sel_instr ? instr_req_i : data_req_i;
    assign w_issue     = rst_ni & w_sel_req & ~w_full;
    assign w_grant     = w_issue & mem_gnt_i;
    assign w_instr_gnt = w_grant & w_sel_instr;
    assign w_data_gnt  = w_grant & ~w_sel_instr;

    assign w_head_instr = (r_src[r_rptr] == SRC_INSTR);
    assign w_pop        = rst_ni & mem_rvalid_i & ~w_empty;
    assign w_stray      = mem_rvalid_i & w_empty;

    // Memory-side request and payload mux; payload reads zero when idle.
    always_comb begin
        mem_req_o   = w_issue;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0000_0000;
        mem_wdata_o = 32'h0000_0000;
        if (w_issue && w_sel_instr) begin
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = 32'h0000_0000;
        end else if (w_issue) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else begin
            mem_we_o    = 1'b0;
            mem_be_o    = 4'h0;
            mem_addr_o  = 32'h0000_0000;
            mem_wdata_o = 32'h0000_0000;
        end
    end

    // Requester-side grants and response routing; rdata reads zero when idle.
    always_comb begin
        instr_gnt_o    = w_instr_gnt;
        data_gnt_o     = w_data_gnt;
        instr_rvalid_o = w_pop & w_head_instr;
        data_rvalid_o  = w_pop & ~w_head_instr;
        instr_rdata_o  = 32'h0000_0000;
        data_rdata_o   = 32'h0000_0000;
        if (instr_rvalid_o) begin
            instr_rdata_o = mem_rdata_i;
        end else begin
            instr_rdata_o = 32'h0000_0000;
        end
        if (data_rvalid_o) begin
            data_rdata_o = mem_rdata_i;
        end else begin
            data_rdata_o = 32'h0000_0000;
        end
    end

    assign busy_o         = ~w_empty;
    assign protocol_err_o = r_protocol_err;

    // Next-state: lock onto the selected source when its request is not
    // accepted, release on the accepting cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue && !mem_gnt_i) begin
                    w_state_nxt = w_sel_instr ? ST_LOCK_I : ST_LOCK_D;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCK_I, ST_LOCK_D: begin
                if (w_grant) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Starvation counter: counts lost fetch cycles, saturating at the limit.
    always_comb begin
        w_starve_nxt = r_starve;
        if (!instr_req_i || w_instr_gnt) begin
            w_starve_nxt = STV_ZERO;
        end else if (r_starve != STV_MAX) begin
            w_starve_nxt = r_starve + STV_ONE;
        end else begin
            w_starve_nxt = r_starve;
        end
    end

    // Arbiter state and starvation counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_starve <= STV_ZERO;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Source-tracking FIFO: push on grant, pop on response, both may coincide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src   <= {MAX_OUTSTANDING{1'b0}};
            r_wptr  <= PTR_ZERO;
            r_rptr  <= PTR_ZERO;
            r_count <= CNT_ZERO;
        end else begin
            if (w_grant) begin
                r_src[r_wptr] <= w_sel_instr;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_grant && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_grant && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Sticky flag for a memory response that has no matching request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_protocol_err <= 1'b0;
        end else if (w_stray) begin
            r_protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed testbench for rv32i_mem_arbiter (MAX_OUTSTANDING=2, STARVE_LIMIT=4).

module tb_rv32i_mem_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;
    logic        protocol_err_o;

    int n_total;
    int n_pass;
    int n_fail;

    rv32i_mem_arbiter #(
        .MAX_OUTSTANDING (2),
        .STARVE_LIMIT    (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o),
        .protocol_err_o (protocol_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_req"},   {31'd0, mem_req_o},      32'd0);
        check({tag, "_mem_addr"},  mem_addr_o,              32'd0);
        check({tag, "_i_gnt"},     {31'd0, instr_gnt_o},    32'd0);
        check({tag, "_d_gnt"},     {31'd0, data_gnt_o},     32'd0);
        check({tag, "_i_rvalid"},  {31'd0, instr_rvalid_o}, 32'd0);
        check({tag, "_d_rvalid"},  {31'd0, data_rvalid_o},  32'd0);
        check({tag, "_busy"},      {31'd0, busy_o},         32'd0);
        check({tag, "_perr"},      {31'd0, protocol_err_o}, 32'd0);
    endtask

    initial begin
        logic exp_i;
        logic prev_i;
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;

        rst_ni       = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'd0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'd0;
        data_wdata_i = 32'd0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        #1;
        check_quiet("reset");
        tick();
        tick();
        rst_ni = 1'b1;

        // ---- instr only: grant same cycle, response next cycle ----
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0100;
        mem_gnt_i    = 1'b1;
        #1;
        check("t1_i_gnt",    {31'd0, instr_gnt_o}, 32'd1);
        check("t1_d_gnt",    {31'd0, data_gnt_o},  32'd0);
        check("t1_mem_addr", mem_addr_o,           32'h0000_0100);
        check("t1_mem_be",   {28'd0, mem_be_o},    32'h0000_000F);
        check("t1_mem_we",   {31'd0, mem_we_o},    32'd0);
        tick();
        instr_req_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0013;
        #1;
        check("t1_busy",     {31'd0, busy_o},         32'd1);
        check("t1_i_rvalid", {31'd0, instr_rvalid_o}, 32'd1);
        check("t1_i_rdata",  instr_rdata_o,           32'h0000_0013);
        check("t1_d_rvalid", {31'd0, data_rvalid_o},  32'd0);
        check("t1_d_rdata",  data_rdata_o,            32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        check("t1_busy_after", {31'd0, busy_o},  32'd0);
        check("t1_rdata_idle", instr_rdata_o,    32'd0);

        // ---- both requesting: data 4 cycles, instr on the 5th ----
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0104;
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_addr_i  = 32'h0000_3000;
        data_wdata_i = 32'hDEAD_BEEF;
        mem_gnt_i    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_rvalid_i = (i > 0);
            mem_rdata_i  = 32'(i);
            #1;
            exp_i = ((i % 5) == 4);
            check($sformatf("t2_i_gnt_%0d", i),    {31'd0, instr_gnt_o}, {31'd0, exp_i});
            check($sformatf("t2_d_gnt_%0d", i),    {31'd0, data_gnt_o},  {31'd0, ~exp_i});
            check($sformatf("t2_mem_addr_%0d", i), mem_addr_o,  exp_i ? 32'h0000_0104 : 32'h0000_3000);
            check($sformatf("t2_mem_wd_%0d", i),   mem_wdata_o, exp_i ? 32'd0 : 32'hDEAD_BEEF);
            if (i > 0) begin
                prev_i = (((i - 1) % 5) == 4);
                check($sformatf("t2_i_rv_%0d", i), {31'd0, instr_rvalid_o}, {31'd0, prev_i});
                check($sformatf("t2_d_rv_%0d", i), {31'd0, data_rvalid_o},  {31'd0, ~prev_i});
            end
            tick();
        end
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0077;
        #1;
        check("t2_drain_i_rv", {31'd0, instr_rvalid_o}, 32'd1);
        check("t2_drain_rd",   instr_rdata_o,           32'h0000_0077);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        check("t2_busy", {31'd0, busy_o}, 32'd0);

        // ---- lock: data waits 3 cycles, instr arrives meanwhile ----
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h0000_2000;
        instr_addr_i = 32'h0000_0400;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) instr_req_i = 1'b1;
            mem_gnt_i = (i == 3);
            #1;
            check($sformatf("t3_mem_addr_%0d", i), mem_addr_o,            32'h0000_2000);
            check($sformatf("t3_d_gnt_%0d", i),    {31'd0, data_gnt_o},   (i == 3) ? 32'd1 : 32'd0);
            check($sformatf("t3_i_gnt_%0d", i),    {31'd0, instr_gnt_o},  32'd0);
            tick();
        end
        data_req_i = 1'b0;
        #1;
        check("t3_i_gnt_after", {31'd0, instr_gnt_o}, 32'd1);
        check("t3_addr_after",  mem_addr_o,           32'h0000_0400);
        tick();
        instr_req_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_AAAA;
        #1;
        check("t3_d_rv",    {31'd0, data_rvalid_o},  32'd1);
        check("t3_d_rdata", data_rdata_o,            32'h0000_AAAA);
        check("t3_i_rv0",   {31'd0, instr_rvalid_o}, 32'd0);
        tick();
        mem_rdata_i = 32'h0000_BBBB;
        #1;
        check("t3_i_rv",    {31'd0, instr_rvalid_o}, 32'd1);
        check("t3_i_rdata", instr_rdata_o,           32'h0000_BBBB);
        tick();
        mem_rvalid_i = 1'b0;

        // ---- order / full ----
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0500;
        mem_gnt_i    = 1'b1;
        #1;
        check("t4_i_gnt", {31'd0, instr_gnt_o}, 32'd1);
        tick();
        instr_req_i = 1'b0;
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_0600;
        #1;
        check("t4_d_gnt", {31'd0, data_gnt_o}, 32'd1);
        tick();
        data_req_i   = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0700;
        #1;
        check("t4_full_req",  {31'd0, mem_req_o},   32'd0);
        check("t4_full_gnt",  {31'd0, instr_gnt_o}, 32'd0);
        check("t4_full_busy", {31'd0, busy_o},      32'd1);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0011;
        #1;
        check("t4_pop1_i_rv",  {31'd0, instr_rvalid_o}, 32'd1);
        check("t4_pop1_rdata", instr_rdata_o,           32'h0000_0011);
        check("t4_pop1_req",   {31'd0, mem_req_o},      32'd0);
        tick();
        mem_rdata_i = 32'h0000_0022;
        #1;
        check("t4_pop2_d_rv",  {31'd0, data_rvalid_o}, 32'd1);
        check("t4_pop2_rdata", data_rdata_o,           32'h0000_0022);
        check("t4_third_gnt",  {31'd0, instr_gnt_o},   32'd1);
        check("t4_third_addr", mem_addr_o,             32'h0000_0700);
        tick();
        instr_req_i = 1'b0;
        mem_gnt_i   = 1'b0;
        mem_rdata_i = 32'h0000_0033;
        #1;
        check("t4_pop3_i_rv", {31'd0, instr_rvalid_o}, 32'd1);
        check("t4_pop3_d_rv", {31'd0, data_rvalid_o},  32'd0);
        tick();

        // ---- stray response with empty FIFO ----
        mem_rdata_i = 32'h0000_0044;
        #1;
        check("t5_busy0",  {31'd0, busy_o},         32'd0);
        check("t5_i_rv",   {31'd0, instr_rvalid_o}, 32'd0);
        check("t5_d_rv",   {31'd0, data_rvalid_o},  32'd0);
        check("t5_perr0",  {31'd0, protocol_err_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        check("t5_perr1", {31'd0, protocol_err_o}, 32'd1);
        tick();
        check("t5_perr2", {31'd0, protocol_err_o}, 32'd1);

        // ---- async reset with two outstanding ----
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0800;
        mem_gnt_i    = 1'b1;
        tick();
        instr_req_i = 1'b0;
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_0900;
        tick();
        instr_req_i = 1'b1;
        #1;
        check("t6_busy_pre", {31'd0, busy_o}, 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        check_quiet("t6_async");
        tick();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        mem_gnt_i   = 1'b0;
        rst_ni      = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0055;
        #1;
        check("t6_late_i_rv", {31'd0, instr_rvalid_o}, 32'd0);
        check("t6_late_d_rv", {31'd0, data_rvalid_o},  32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        check("t6_late_perr", {31'd0, protocol_err_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
